// File: rtl/lvds_rx_phase_ctrl_if.sv
// lvds_rx_phase_ctrl_if: control, status and PLL dynamic-phase signals of the phase calibrator
interface lvds_rx_phase_ctrl_if;
  logic start, pll_lock, pattern_ok, pll_reset, busy, done, fail;
  logic [3:0] psda, dutyda, fdly, best_phase;
  logic [4:0] win_len;
  modport master(
    output start, pll_lock, pattern_ok,
    input pll_reset, psda, dutyda, fdly, busy, done, fail, best_phase, win_len
  );
  modport slave(
    input start, pll_lock, pattern_ok,
    output pll_reset, psda, dutyda, fdly, busy, done, fail, best_phase, win_len
  );
endinterface

// File: rtl/lvds_rx_phase_ctrl.sv
// lvds_rx_phase_ctrl: PLL reset/lock then 16-step psda sweep, applies centre of longest good window
module lvds_rx_phase_ctrl #(
  parameter int RST_CYC = 16,
  parameter int LOCK_WAIT = 65535,
  parameter int SETTLE_CYC = 64,
  parameter int CHECK_CYC = 256,
  parameter int MAX_RETRY = 3,
  parameter logic [3:0] DUTY_DEFAULT = 4'b1000,
  parameter logic [3:0] FDLY_DEFAULT = 4'b0000
) (
  input logic clk,
  input logic reset,
  lvds_rx_phase_ctrl_if.slave bus
);
  typedef enum logic [3:0] {IDLE, PLL_RST, WAIT_LOCK, SETTLE, CHECK, NEXT, APPLY, DONE, FAIL} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [3:0] retry, psda_r, best_phase_r, cur_start, best_start, cur_start_n, best_start_n, sel;
  logic [4:0] cur_len, best_len, cur_len_n, best_len_n, win_len_r;
  logic ok, rest, take, lost, cnt_end;
  assign rest = state inside {IDLE, DONE, FAIL};
  assign take = bus.start && rest;
  assign lost = !bus.pll_lock && state inside {SETTLE, CHECK, NEXT, APPLY};
  assign cnt_end = state == PLL_RST ? cnt == 16'(RST_CYC - 1) :
                   state == WAIT_LOCK ? cnt == 16'(LOCK_WAIT - 1) :
                   state == CHECK ? cnt == 16'(CHECK_CYC - 1) : cnt == 16'(SETTLE_CYC - 1);
  // run tracking is non-circular; a strictly longer run replaces the best, so ties keep the first
  assign cur_len_n = ok ? cur_len + 5'd1 : 5'd0;
  assign cur_start_n = ok && cur_len == 5'd0 ? psda_r : cur_start;
  assign best_len_n = cur_len_n > best_len ? cur_len_n : best_len;
  assign best_start_n = cur_len_n > best_len ? cur_start_n : best_start;
  assign sel = best_start_n + 4'((best_len_n - 5'd1) >> 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      retry <= '0;
      psda_r <= '0;
      best_phase_r <= '0;
      win_len_r <= '0;
      ok <= 1'b0;
      cur_start <= '0;
      cur_len <= '0;
      best_start <= '0;
      best_len <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? 16'd0 : cnt + 16'd1;
      if (take) begin
        retry <= '0;
        win_len_r <= '0;
      end else if (lost) retry <= retry + 4'd1;
      if (nxt == PLL_RST) psda_r <= '0;
      if (state == PLL_RST) begin
        cur_start <= '0;
        cur_len <= '0;
        best_start <= '0;
        best_len <= '0;
      end
      if (state == SETTLE) ok <= 1'b1;
      if (state == CHECK) ok <= ok & bus.pattern_ok;
      if (state == NEXT) begin
        cur_start <= cur_start_n;
        cur_len <= cur_len_n;
        best_start <= best_start_n;
        best_len <= best_len_n;
      end
      if (state == NEXT && nxt == SETTLE) psda_r <= psda_r + 4'd1;
      if (nxt == APPLY && state == NEXT) begin
        psda_r <= sel;
        best_phase_r <= sel;
        win_len_r <= best_len_n;
      end
      if (nxt == FAIL && state != FAIL) begin
        win_len_r <= '0;
        if (state == NEXT) psda_r <= '0;
      end
    end
  end
  always_comb begin
    nxt = state;
    if (take) nxt = PLL_RST;
    else if (lost) nxt = retry == 4'(MAX_RETRY) ? FAIL : PLL_RST;
    else
      case (state)
        PLL_RST: nxt = cnt_end ? WAIT_LOCK : PLL_RST;
        WAIT_LOCK: nxt = bus.pll_lock ? SETTLE : cnt_end ? FAIL : WAIT_LOCK;
        SETTLE: nxt = cnt_end ? CHECK : SETTLE;
        CHECK: nxt = cnt_end ? NEXT : CHECK;
        NEXT: nxt = psda_r != 4'd15 ? SETTLE : best_len_n == 5'd0 ? FAIL : APPLY;
        APPLY: nxt = cnt_end ? DONE : APPLY;
        default: nxt = state;
      endcase
  end
  always_comb begin
    bus.pll_reset = state == PLL_RST;
    bus.busy = !rest;
    bus.done = state == DONE;
    bus.fail = state == FAIL;
  end
  assign bus.psda = psda_r;
  assign bus.dutyda = DUTY_DEFAULT;
  assign bus.fdly = FDLY_DEFAULT;
  assign bus.best_phase = best_phase_r;
  assign bus.win_len = win_len_r;
endmodule

// File: doc/lvds_rx_phase_ctrl.md
Name: lvds_rx_phase_ctrl

Overview:
Calibration sequencer for the LVDS receive PLL's dynamic phase/duty/delay inputs (psda/dutyda/fdly) and its reset.
- On start: resets the PLL, waits for lock, then sweeps all 16 PSDA phase steps.
- At each step, judges data capture using the word aligner's pattern_ok flag during training.
- Selects the centre of the longest contiguous good window and applies it.
- Sits between the rx PLL wrapper and the 7:1 deserializer/aligner; reports status to top-level control.

Parameters:
RST_CYC, 16, cycles pll_reset held high per reset attempt
LOCK_WAIT, 65535, max cycles waiting for pll_lock before timeout
SETTLE_CYC, 64, cycles after any psda change before sampling pattern_ok
CHECK_CYC, 256, cycles pattern_ok is sampled per phase step
MAX_RETRY, 3, lock-loss restarts allowed per calibration before fail
DUTY_DEFAULT, 4'b1000, constant driven on dutyda
FDLY_DEFAULT, 4'b0000, constant driven on fdly

Ports:
clk  input  1  controller clock (free-running, not PLL-derived)
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle calibration request
pll_lock  input  1  PLL lock, pre-synchronised to clk
pattern_ok  input  1  aligner flag, current word matches training pattern (clk domain)
pll_reset  output  1  drives PLL reset
psda  output  4  PLL dynamic phase select
dutyda  output  4  PLL dynamic duty select
fdly  output  4  PLL fine delay select
busy  output  1  calibration in progress
done  output  1  calibration succeeded (level)
fail  output  1  calibration failed (level)
best_phase  output  4  applied phase step
win_len  output  5  length of chosen good window, 0..16

Behaviour:
Reset values:
- pll_reset=0, psda=0, dutyda=DUTY_DEFAULT, fdly=FDLY_DEFAULT
- busy=0, done=0, fail=0, best_phase=0, win_len=0
- state IDLE; all counters and retry count cleared

dutyda and fdly are constant at their defaults in every state.

States:
- IDLE: wait for start.
- PLL_RST: pll_reset=1 for exactly RST_CYC cycles, then WAIT_LOCK.
- WAIT_LOCK: count cycles.
  - pll_lock=1 → SETTLE with psda=0 and window trackers cleared.
  - LOCK_WAIT cycles elapse without lock → FAIL.
- SETTLE: hold psda for SETTLE_CYC cycles, ignoring pattern_ok, then CHECK.
- CHECK: sample for CHECK_CYC cycles. The phase is good iff pattern_ok=1 on every sampled cycle, then NEXT.
- NEXT: update window trackers.
  - psda=15 → APPLY.
  - Otherwise psda+1 → SETTLE.
- APPLY: psda=best_phase, wait SETTLE_CYC cycles, then DONE.
- DONE: done=1. FAIL: fail=1.

Handshake:
- start is accepted only in IDLE, DONE or FAIL; it is ignored while busy.
- Acceptance clears done/fail/win_len and the retry count. PLL_RST begins the next cycle; busy rises that same cycle.
- busy=1 in every state except IDLE, DONE and FAIL.

Lock loss:
- pll_lock=0 in SETTLE, CHECK, NEXT or APPLY → retry count +1, then PLL_RST (full sweep restart).
- If retry count would exceed MAX_RETRY → FAIL instead.

Window tracking:
- Non-circular; phases 15 and 0 are not adjacent.
- cur_start and cur_len (5 bits) track the current run of good phases; a bad phase sets cur_len=0.
- After each update, if cur_len > best_len (strictly greater), copy it into best_start/best_len. On equal length, the first-found window wins.

Selection (at end of sweep):
- best_len=0 → FAIL; psda returns to 0.
- Otherwise best_phase = best_start + ((best_len-1)>>1), using 4-bit result arithmetic; win_len=best_len.

Outputs:
- best_phase and win_len update on entry to APPLY and hold until the next accepted start.
- On FAIL, best_phase is left unchanged and win_len=0.

Reset mid-operation: synchronous reset forces all reset values on the next edge from any state. pll_reset is released (0).

Test Plan:
- All phases good: start, lock after 100 cycles, pattern_ok=1 → win_len=16, best_phase=7, psda=7, done=1, fail=0.
- Good phases 3..9 only → win_len=7, best_phase=6, done=1.
- Good windows 1..3 and 10..14 → win_len=5, best_phase=12; then tied windows 0..2 and 8..10 → best_phase=1.
- pattern_ok=0 throughout → fail=1, win_len=0, psda=0. Separately, pll_lock held 0 → fail asserted exactly RST_CYC+LOCK_WAIT cycles after start is accepted.
- pll_lock drops during CHECK of phase 5 → pll_reset pulses for RST_CYC cycles and the sweep restarts at psda=0. Four drops in total (one more than MAX_RETRY=3) → fail=1.
- Reset asserted mid-sweep (psda=9) → next cycle all outputs at reset values. start during busy → no effect; start in DONE → recalibration with done cleared.
